// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and the Gray-code helpers
// used by both the read-side and write-side pointer logic.
package fifo_pkg;

    localparam int FIFO_ADDRESSSIZE = 4;
    localparam int FIFO_DATASIZE    = 8;
    localparam int FIFO_AETHRESH    = 4;
    localparam int FIFO_CODE_W      = 32;

    // Operate on a fixed wide word; callers zero-extend and truncate, which is
    // exact for both conversions because leading zeros stay zeros.
    function automatic logic [FIFO_CODE_W-1:0] bin2gray(input logic [FIFO_CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FIFO_CODE_W-1:0] gray2bin(input logic [FIFO_CODE_W-1:0] g);
        logic [FIFO_CODE_W-1:0] b;
        b[FIFO_CODE_W-1] = g[FIFO_CODE_W-1];
        for (int i = FIFO_CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_w2r.sv
// Two-flop synchronizer bringing the write-domain Gray pointer into rclk.
module fifo_sync_w2r #(
    parameter int W = 6
) (
    input  logic         rclk,
    input  logic         rrst_n,
    input  logic [W-1:0] wptr,
    output logic [W-1:0] rq2_wptr
);

    logic [W-1:0] rq1_wptr_q;
    logic [W-1:0] rq2_wptr_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
        end else begin
            rq1_wptr_q <= wptr;
            rq2_wptr_q <= rq1_wptr_q;
        end
    end

    assign rq2_wptr = rq2_wptr_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty/level flags and
// a first-word-fall-through valid/ready output stage over the registered memory port.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int addresssize = FIFO_ADDRESSSIZE,
    parameter int datasize    = FIFO_DATASIZE,
    parameter int aethresh    = FIFO_AETHRESH
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [addresssize+1:0] wptr,
    input  logic [datasize-1:0]    rdata,
    output logic                   rclken,
    output logic [addresssize:0]   raddr,
    output logic [addresssize+1:0] rptr,
    output logic                   rempty,
    output logic                   ralmost_empty,
    output logic [addresssize+1:0] rlevel,
    output logic                   rvalid,
    output logic [datasize-1:0]    dout,
    input  logic                   rready
);

    localparam int PW = addresssize + 2;

    logic [PW-1:0] rq2_wptr;

    fifo_sync_w2r #(.W(PW)) u_sync (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr     (wptr),
        .rq2_wptr (rq2_wptr)
    );

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          rvalid_q, rvalid_d;

    always_comb begin
        // Issue when there is a word and the output slot is free or draining now.
        rclken          = !rempty_q && (!rvalid_q || rready);
        rbin_d          = rbin_q + PW'(rclken);
        rptr_d          = PW'(bin2gray(FIFO_CODE_W'(rbin_d)));
        rempty_d        = (rptr_d == rq2_wptr);
        rlevel_d        = PW'(gray2bin(FIFO_CODE_W'(rq2_wptr)) - FIFO_CODE_W'(rbin_d));
        ralmost_empty_d = (FIFO_CODE_W'(rlevel_d) <= FIFO_CODE_W'(aethresh));
        rvalid_d        = rvalid_q;
        if (rclken) begin
            rvalid_d = 1'b1;
        end else if (rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rvalid_q        <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rvalid_q        <= rvalid_d;
        end
    end

    assign raddr         = rbin_q[addresssize:0];
    assign rptr          = rptr_q;
    assign rlevel        = rlevel_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rvalid        = rvalid_q;
    // The memory read register only loads on rclken, so this holds under backpressure.
    assign dout          = rdata;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized bench for fifo_read_ctrl against a count-based model of the FIFO.
module tb_fifo_read_ctrl;

    localparam int AS = 4;
    localparam int DS = 8;
    localparam int AE = 4;
    localparam int DEPTH = 32;

    logic          rclk;
    logic          rrst_n;
    logic [AS+1:0] wptr;
    logic [DS-1:0] rdata;
    logic          rclken;
    logic [AS:0]   raddr;
    logic [AS+1:0] rptr;
    logic          rempty;
    logic          ralmost_empty;
    logic [AS+1:0] rlevel;
    logic          rvalid;
    logic [DS-1:0] dout;
    logic          rready;

    fifo_read_ctrl #(.addresssize(AS), .datasize(DS), .aethresh(AE)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .wptr          (wptr),
        .rdata         (rdata),
        .rclken        (rclken),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .rvalid        (rvalid),
        .dout          (dout),
        .rready        (rready)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Dual-port memory: registered read port, writes come from the stimulus.
    logic [DS-1:0] mem [DEPTH];
    always @(posedge rclk) if (rclken) rdata <= mem[raddr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: words written / seen through the 2-edge sync / issued, as plain integers.
    int written, seen1, seen2, issued, level_m;
    bit vld_m, empty_m, ae_m;
    logic [DS-1:0] exp_dout;

    function automatic int gray(input int x);
        int b;
        b = x % 64;
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        written = 0; seen1 = 0; seen2 = 0; issued = 0; level_m = 0;
        vld_m = 0; empty_m = 1; ae_m = 1;
    endtask

    task automatic tick(input bit rdy);
        bit issue;
        logic [DS-1:0] idata;
        @(negedge rclk);
        rready = rdy;
        wptr   = (AS+2)'(gray(written));
        #1;
        issue = !empty_m && (!vld_m || rdy);
        idata = mem[issued % DEPTH];
        chk("rclken", 32'(rclken), 32'(issue));
        chk("rvalid", 32'(rvalid), 32'(vld_m));
        chk("rempty", 32'(rempty), 32'(empty_m));
        chk("rlevel", 32'(rlevel), 32'(level_m));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(ae_m));
        chk("rptr", 32'(rptr), 32'(gray(issued)));
        chk("raddr", 32'(raddr), 32'(issued % DEPTH));
        if (vld_m) chk("dout", 32'(dout), 32'(exp_dout));
        @(posedge rclk);
        #1;
        if (issue) begin
            vld_m = 1; exp_dout = idata; issued++;
        end else if (rdy) begin
            vld_m = 0;
        end
        empty_m = (issued == seen2);
        level_m = seen2 - issued;
        ae_m    = (level_m <= AE);
        seen2   = seen1;
        seen1   = written;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        rready = 1'b1;
        #1;
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_rlevel", 32'(rlevel), 32'd0);
        chk("rst_ae", 32'(ralmost_empty), 32'd1);
        chk("rst_rclken", 32'(rclken), 32'd0);
        model_reset();
        wptr = '0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        chk("rst_hold_rclken", 32'(rclken), 32'd0);
        chk("rst_hold_rvalid", 32'(rvalid), 32'd0);
        rrst_n = 1'b1;
    endtask

    initial begin
        int n;
        rrst_n = 1'b0;
        rready = 1'b0;
        wptr   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        do_reset();

        // Single word: first rvalid lands four edges after the write pointer moves.
        mem[0] = 8'hA5;
        written = 1;
        n = 0;
        do begin
            tick(1'b0);
            n++;
        end while (!rvalid && n < 10);
        chk("single_latency", 32'(n), 32'd4);
        chk("single_dout", 32'(dout), 32'hA5);
        tick(1'b1);
        repeat (2) tick(1'b0);
        chk("single_rptr", 32'(rptr), 32'h1);

        // Full burst: 32 preloaded words drained back-to-back.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = DS'(i);
        written = DEPTH;
        tick(1'b1);
        chk("full_wptr", 32'(wptr), 32'd48);
        repeat (40) tick(1'b1);
        chk("full_drained", 32'(issued), 32'd32);

        // Backpressure: three words, stall, then release.
        do_reset();
        for (int i = 0; i < 3; i++) mem[i] = DS'($urandom);
        written = 3;
        repeat (9) tick(1'b0);
        chk("bp_level", 32'(rlevel), 32'd2);
        repeat (5) tick(1'b1);

        // Almost-empty: six words drained one at a time.
        do_reset();
        for (int i = 0; i < 6; i++) mem[i] = DS'($urandom);
        written = 6;
        repeat (5) tick(1'b0);
        repeat (8) begin
            tick(1'b1);
            tick(1'b0);
        end

        // Random traffic long enough to wrap the 6-bit pointer.
        do_reset();
        n = 0;
        while (issued < 110 && n < 2000) begin
            if ($urandom_range(0, 3) != 0 && written - issued < DEPTH) begin
                mem[written % DEPTH] = DS'($urandom);
                written++;
            end
            tick($urandom_range(0, 99) < 60);
            n++;
        end
        chk("wrap_count", 32'(issued >= 100), 32'd1);

        // Reset in the middle of a burst.
        for (int i = 0; i < 20; i++) begin
            if (written - issued < DEPTH) begin
                mem[written % DEPTH] = DS'($urandom);
                written++;
            end
            tick(1'b1);
        end
        do_reset();
        repeat (4) tick(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
